// File: rtl/key_debounce_pkg.sv
//------------------------------------------------------------------------------
// Module : key_pkg
// Brief  : Shared types and constants for the key debounce block.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_if.sv
//------------------------------------------------------------------------------
// Module : key_debounce_if
// Brief  : Press-event stream (valid/ready) plus sticky overflow flag.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface key_debounce_if #(
    parameter int CODE_W = 3
);
    logic              evt_valid;
    logic [CODE_W-1:0] evt_code;
    logic              evt_ready;
    logic              evt_overflow;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_overflow,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_overflow,
        output evt_ready
    );
endinterface

`default_nettype wire

// File: rtl/key_debounce_cell.sv
//------------------------------------------------------------------------------
// Module : key_debounce_cell
// Brief  : One key: 2-flop synchroniser, polarity fix, debounce FSM and pulses.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce_cell
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_key_raw,
    output logic      o_level,
    output logic      o_press,
    output logic      o_release
);

    localparam int           CNT_W       = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic         c_RAW_IDLE  = ACTIVE_LOW;

    localparam logic [1:0] c_ST_IDLE         = IDLE;
    localparam logic [1:0] c_ST_PRESS_WAIT   = PRESS_WAIT;
    localparam logic [1:0] c_ST_PRESSED      = PRESSED;
    localparam logic [1:0] c_ST_RELEASE_WAIT = RELEASE_WAIT;

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_synced;

    assign w_synced = ACTIVE_LOW ? ~r_sync2 : r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= c_RAW_IDLE;
            r_sync2   <= c_RAW_IDLE;
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_key_raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_synced) begin
                        r_state <= c_ST_PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                c_ST_PRESS_WAIT: begin
                    if (!w_synced) begin
                        r_state <= c_ST_IDLE;
                    end else if (r_cnt == c_TERM) begin
                        r_state <= c_ST_PRESSED;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_ST_PRESSED: begin
                    if (!w_synced) begin
                        r_state <= c_ST_RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                c_ST_RELEASE_WAIT: begin
                    if (w_synced) begin
                        r_state <= c_ST_PRESSED;
                    end else if (r_cnt == c_TERM) begin
                        r_state   <= c_ST_IDLE;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
//------------------------------------------------------------------------------
// Module : key_debounce
// Brief  : Debounced key bank with level/pulse outputs and a one-entry event slot.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 8,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [NUM_KEYS-1:0] key_in,
    output logic      [NUM_KEYS-1:0] key_level,
    output logic      [NUM_KEYS-1:0] key_press,
    output logic      [NUM_KEYS-1:0] key_release,
    key_debounce_if.master           evt
);

    localparam int CODE_W = (clog2(NUM_KEYS) < 1) ? 1 : clog2(NUM_KEYS);

    logic              r_valid;
    logic [CODE_W-1:0] r_code;
    logic              r_overflow;
    logic [CODE_W-1:0] w_low_idx;
    logic              w_any_press;
    logic              w_multi_press;
    logic              w_can_load;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_cell
        key_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .i_key_raw (key_in[g]),
            .o_level   (key_level[g]),
            .o_press   (key_press[g]),
            .o_release (key_release[g])
        );
    end

    // Lowest set index wins the slot; scan downward so it is assigned last.
    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_press[i]) begin
                w_low_idx = CODE_W'(i);
            end
        end
    end

    assign w_any_press   = |key_press;
    assign w_multi_press = |(key_press & (key_press - NUM_KEYS'(1)));
    assign w_can_load    = !r_valid || evt.evt_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_code     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_any_press && w_can_load) begin
                r_valid <= 1'b1;
                r_code  <= w_low_idx;
            end else if (r_valid && evt.evt_ready) begin
                r_valid <= 1'b0;
            end
            if (w_any_press && (!w_can_load || w_multi_press)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign evt.evt_valid    = r_valid;
    assign evt.evt_code     = r_code;
    assign evt.evt_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
//------------------------------------------------------------------------------
// Module : tb_key_debounce
// Brief  : Directed scenarios plus random key/ready traffic against a run-length model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_debounce;

    localparam int NK = 8;
    localparam int DB = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_in = '1;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    always #5 clk = ~clk;

    key_debounce_if #(.CODE_W(CW)) evt_if ();
    assign evt_if.evt_ready = ready;

    key_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .evt         (evt_if)
    );

    // Reference model: a key flips once its pressed-sense pin, seen two edges late,
    // has disagreed with the accepted level for DB+1 consecutive edges.
    logic [NK-1:0] h1, h2, m_lvl, m_prs, m_rel;
    int            run [NK];
    logic          m_v, m_ovf;
    logic [CW-1:0] m_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] lowest(input logic [NK-1:0] v);
        for (int i = 0; i < NK; i++) if (v[i]) return CW'(i);
        return '0;
    endfunction

    task automatic model_edge();
        logic [NK-1:0] pin_p;
        pin_p = ~key_in;
        if (rst) begin
            h1 = '0; h2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
            m_v = 1'b0; m_ovf = 1'b0; m_code = '0;
            for (int k = 0; k < NK; k++) run[k] = 0;
        end else begin
            if (m_prs != '0) begin
                if (!m_v || ready) begin
                    m_v    = 1'b1;
                    m_code = lowest(m_prs);
                    if ($countones(m_prs) > 1) m_ovf = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_v && ready) begin
                m_v = 1'b0;
            end
            m_prs = '0;
            m_rel = '0;
            for (int k = 0; k < NK; k++) begin
                if (h2[k] != m_lvl[k]) begin
                    run[k]++;
                    if (run[k] == DB + 1) begin
                        m_lvl[k] = ~m_lvl[k];
                        if (m_lvl[k]) m_prs[k] = 1'b1;
                        else          m_rel[k] = 1'b1;
                        run[k] = 0;
                    end
                end else begin
                    run[k] = 0;
                end
            end
            h2 = h1;
            h1 = pin_p;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        edge_n++;
        #1;
        chk("level",    32'(key_level),           32'(m_lvl));
        chk("press",    32'(key_press),           32'(m_prs));
        chk("release",  32'(key_release),         32'(m_rel));
        chk("valid",    32'(evt_if.evt_valid),    32'(m_v));
        chk("code",     32'(evt_if.evt_code),     32'(m_code));
        chk("overflow", 32'(evt_if.evt_overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        key_in = '1;
        ready  = 1'b0;
        step();
        step();
        chk("rst_level", 32'(key_level), 32'd0);
        chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
        chk("rst_ovf",   32'(evt_if.evt_overflow), 32'd0);
        rst    = 1'b0;
        edge_n = 0;
    endtask

    // Steps until key_press[k] is seen; returns edge number or -1 on timeout.
    task automatic wait_press(input int k, output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (key_press[k] && at < 0) at = edge_n;
        end
    endtask

    initial begin
        int at;
        int seen;

        // Clean press on key 3
        do_reset();
        key_in[3] = 1'b0;
        wait_press(3, at);
        chk("press_lat", 32'(at), 32'd7);
        chk("evt_code3", 32'(evt_if.evt_code), 32'd3);

        // Bounce on key 0: 2-cycle phases never satisfy the hold time
        do_reset();
        seen = 0;
        for (int p = 0; p < 4; p++) begin
            key_in[0] = p[0];
            for (int c = 0; c < 2; c++) begin
                step();
                seen = seen | int'(key_press[0]);
            end
        end
        key_in[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            seen = seen | int'(key_press[0]);
        end
        chk("bounce_press", 32'(seen), 32'd0);
        chk("bounce_level", 32'(key_level[0]), 32'd0);

        // Release on key 5
        do_reset();
        key_in[5] = 1'b0;
        wait_press(5, at);
        key_in[5] = 1'b1;
        edge_n = 0;
        at = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (key_release[5] && at < 0) at = edge_n;
        end
        chk("release_lat", 32'(at), 32'd7);
        chk("release_lvl", 32'(key_level[5]), 32'd0);

        // Simultaneous presses on keys 2 and 6
        do_reset();
        key_in[2] = 1'b0;
        key_in[6] = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("simul_code", 32'(evt_if.evt_code), 32'd2);
        chk("simul_ovf",  32'(evt_if.evt_overflow), 32'd1);

        // Backpressure: key 1 fills the slot, key 4 is dropped
        do_reset();
        key_in[1] = 1'b0;
        for (int i = 0; i < 10; i++) step();
        key_in[4] = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("bp_code",  32'(evt_if.evt_code), 32'd1);
        chk("bp_ovf",   32'(evt_if.evt_overflow), 32'd1);
        ready = 1'b1;
        step();
        chk("bp_drain", 32'(evt_if.evt_valid), 32'd0);

        // Reset while key 7 is mid-debounce (cnt=2 after edge 5)
        do_reset();
        key_in[7] = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        chk("mid_rst_out", 32'({key_level, key_press, key_release}), 32'd0);
        chk("mid_rst_evt", 32'({evt_if.evt_valid, evt_if.evt_overflow}), 32'd0);
        rst = 1'b0;
        edge_n = 0;
        wait_press(7, at);
        chk("mid_rst_lat", 32'(at), 32'd7);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 5) == 0) key_in[k] = ~key_in[k];
            ready = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
